// File: rtl/serial_sub_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_if
// Purpose  : Handshake and data bundle for the bit-serial subtractor.
//            Operand side: in_valid/in_ready with a, b, bin.
//            Result side : out_valid/out_ready with diff, borrow_out, plus busy.
// Modports : master - operand producer / result consumer (drives requests)
//            slave  - the subtractor itself
// Revision : 1.0 - initial release
// ============================================================================
interface serial_sub_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         busy;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, borrow_out, busy
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, borrow_out, busy
  );
endinterface
`default_nettype wire

// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub
// Purpose  : Bit-serial W-bit unsigned subtractor, diff = a - b - bin.
//            One full-subtractor cell plus a borrow flop, iterated LSB-first
//            over W cycles. Holds one operation at a time.
// Ports    : clk        - rising-edge clock
//            rst        - asynchronous reset, active-high
//            bus.slave  - in_valid/in_ready/a/b/bin operand handshake,
//                         out_valid/out_ready/diff/borrow_out result
//                         handshake, busy status (high in SHIFT or DONE)
// Timing   : accept at edge T, out_valid high after edge T+W, next accept
//            no earlier than edge T+W+2.
// Revision : 1.0 - initial release
// ============================================================================
module serial_sub #(
  parameter int W = 8
) (
  input  logic       clk,
  input  logic       rst,
  serial_sub_if.slave bus
);

  localparam int                 c_CNT_W = $clog2(W);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [W-1:0]       r_sa;
  logic [W-1:0]       r_sb;
  logic [W-1:0]       r_res;
  logic               r_br;
  logic [c_CNT_W-1:0] r_cnt;
  logic [W-1:0]       r_diff;
  logic               r_borrow_out;

  logic               w_x;
  logic               w_y;
  logic               w_d;
  logic               w_br_next;
  logic               w_last;
  logic [W-1:0]       w_res_next;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_busy;

  // Full-subtractor cell on the current LSBs.
  assign w_x        = r_sa[0];
  assign w_y        = r_sb[0];
  assign w_d        = w_x ^ w_y ^ r_br;
  assign w_br_next  = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
  assign w_last     = (r_cnt == c_LAST);
  // Result fills from the top so that after W shifts bit 0 holds the LSB.
  assign w_res_next = {w_d, r_res[W-1:1]};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and status outputs. Outputs depend on state only, so there is
  // no combinational path from in_valid or out_ready to any output.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_next_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: operand capture, serial iteration, result registers.
  // diff/borrow_out change only on the DONE-entry edge and are otherwise held.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa         <= '0;
      r_sb         <= '0;
      r_res        <= '0;
      r_br         <= 1'b0;
      r_cnt        <= '0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_sa  <= bus.a;
            r_sb  <= bus.b;
            r_br  <= bus.bin;
            r_cnt <= '0;
          end
        end
        S_SHIFT: begin
          r_sa  <= {1'b0, r_sa[W-1:1]};
          r_sb  <= {1'b0, r_sb[W-1:1]};
          r_res <= w_res_next;
          r_br  <= w_br_next;
          if (w_last) begin
            // Counter parks at W-1 rather than wrapping.
            r_diff       <= w_res_next;
            r_borrow_out <= w_br_next;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.busy       = w_busy;
  assign bus.diff       = r_diff;
  assign bus.borrow_out = r_borrow_out;

endmodule
`default_nettype wire
